rr_sel_arbiter: RTL and testbench

//  Round-robin request arbiter that drives the 2-bit sel of the downstream 4-to-1 mux.
//  - Four sources raise req; the block grants one at a time and holds sel stable until
//    the consumer acks.
//  - Fairness: after a completed (or timed-out) grant, the granted channel gets lowest

---
 rtl/rr_sel_arb_pkg.sv | 14 +
 rtl/rr_sel_arbiter_if.sv | 26 ++
 rtl/rr_sel_arbiter_pick.sv | 26 ++
 rtl/rr_sel_arbiter.sv | 131 +++++++++++++
 tb/tb_rr_sel_arbiter.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/rr_sel_arb_pkg.sv
// Shared types and constants for the round-robin mux-select arbiter.
package rr_sel_arb_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef logic [SEL_W-1:0] ch_t;

  typedef enum logic {
    IDLE,
    GRANT
  } arb_state_t;

endpackage

// File: rtl/rr_sel_arbiter_if.sv
// Request/grant bundle between the four sources, the consumer and the arbiter.
interface rr_sel_arbiter_if
  import rr_sel_arb_pkg::*;
#(
  parameter int CNT_W = 8
);

  logic [NUM_CH-1:0] req;
  logic              ack;
  ch_t               sel;
  logic [NUM_CH-1:0] grant;
  logic              valid;
  logic [CNT_W-1:0]  done_cnt;
  logic              timeout;

  modport master (
    output req, ack,
    input  sel, grant, valid, done_cnt, timeout
  );

  modport slave (
    input  req, ack,
    output sel, grant, valid, done_cnt, timeout
  );

endinterface

// File: rtl/rr_sel_arbiter_pick.sv
// Round-robin pick: first set request searching upward from last_ch+1, wrapping.
module rr_pick
  import rr_sel_arb_pkg::*;
(
  input  logic [NUM_CH-1:0] req_i,
  input  ch_t               last_ch_i,
  output logic              any_o,
  output ch_t               winner_o
);

  // NOTE: every output gets a default before the search so no latch is inferred.
  always_comb begin
    ch_t idx;
    any_o    = 1'b0;
    winner_o = '0;
    idx      = last_ch_i;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = idx + ch_t'(1);
      if (!any_o && req_i[idx]) begin
        any_o    = 1'b1;
        winner_o = idx;
      end
    end
  end

endmodule

// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter driving the select of a 4:1 mux; holds sel until ack.
// Optional forced release after TIMEOUT_CYC idle grant cycles: RR_SEL_ARB_TIMEOUT_EN.
module rr_sel_arbiter
  import rr_sel_arb_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  rr_sel_arbiter_if.slave    bus
);

  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
    $error("rr_sel_arbiter: TIMEOUT_CYC out of range 2..65535");
  end

  arb_state_t       state_q, state_d;
  ch_t              sel_q, sel_d;
  ch_t              last_ch_q, last_ch_d;
  logic [CNT_W-1:0] done_cnt_q, done_cnt_d;
  logic             tmo_hit;

`ifdef RR_SEL_ARB_TIMEOUT_EN
  logic [15:0]      wait_q, wait_d;
  logic             timeout_q;
`endif

  // During GRANT a release re-picks relative to the channel just served.
  ch_t  pick_last;
  logic pick_any;
  ch_t  pick_winner;

  assign pick_last = (state_q == GRANT) ? sel_q : last_ch_q;

  rr_pick u_pick (
    .req_i     (bus.req),
    .last_ch_i (pick_last),
    .any_o     (pick_any),
    .winner_o  (pick_winner)
  );

  // NOTE: state registers use non-blocking assignments so all update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      last_ch_q  <= ch_t'(NUM_CH - 1);
      done_cnt_q <= '0;
`ifdef RR_SEL_ARB_TIMEOUT_EN
      wait_q     <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      last_ch_q  <= last_ch_d;
      done_cnt_q <= done_cnt_d;
`ifdef RR_SEL_ARB_TIMEOUT_EN
      wait_q     <= wait_d;
      timeout_q  <= tmo_hit;
`endif
    end
  end

`ifdef RR_SEL_ARB_TIMEOUT_EN
  // A withdrawn request releases without a timeout; a same-cycle ack beats the timeout.
  assign tmo_hit = (state_q == GRANT) && !bus.ack && bus.req[sel_q] &&
                   (wait_q == 16'(TIMEOUT_CYC - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    last_ch_d  = last_ch_q;
    done_cnt_d = done_cnt_q;
`ifdef RR_SEL_ARB_TIMEOUT_EN
    wait_d     = wait_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          sel_d   = pick_winner;
          state_d = GRANT;
`ifdef RR_SEL_ARB_TIMEOUT_EN
          wait_d  = '0;
`endif
        end
      end
      GRANT: begin
        if (bus.ack) begin
          done_cnt_d = done_cnt_q + CNT_W'(1);
        end
        if (bus.ack || tmo_hit) begin
          last_ch_d = sel_q;
          if (pick_any) begin
            sel_d  = pick_winner;
`ifdef RR_SEL_ARB_TIMEOUT_EN
            wait_d = '0;
`endif
          end else begin
            state_d = IDLE;
          end
        end else if (!bus.req[sel_q]) begin
          state_d = IDLE;
        end else begin
`ifdef RR_SEL_ARB_TIMEOUT_EN
          wait_d = wait_q + 16'd1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.sel      = sel_q;
    bus.valid    = (state_q == GRANT);
    bus.grant    = '0;
    if (state_q == GRANT) bus.grant[sel_q] = 1'b1;
    bus.done_cnt = done_cnt_q;
`ifdef RR_SEL_ARB_TIMEOUT_EN
    bus.timeout  = timeout_q;
`else
    bus.timeout  = 1'b0;
`endif
  end

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Self-checking bench for rr_sel_arbiter: directed scenarios plus random traffic
// compared against a channel-level reference model (honours RR_SEL_ARB_TIMEOUT_EN).
module tb_rr_sel_arbiter;

  localparam int CNT_W       = 2;
  localparam int TIMEOUT_CYC = 4;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  rr_sel_arbiter_if #(.CNT_W(CNT_W)) bus ();

  rr_sel_arbiter #(
    .CNT_W       (CNT_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: granted channel (-1 when none), last served channel, counters.
  int m_cur, m_last, m_cnt, m_sel, m_wait;
  bit m_tmo;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cur  = -1;
    m_last = 3;
    m_cnt  = 0;
    m_sel  = 0;
    m_wait = 0;
    m_tmo  = 1'b0;
  endtask

  function automatic int model_pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [3:0] r, input logic a);
    bit to_hit;
    to_hit = 1'b0;
    m_tmo  = 1'b0;
    if (m_cur < 0) begin
      if (r != 4'b0000) begin
        m_cur  = model_pick(r, m_last);
        m_wait = 0;
      end
    end else begin
`ifdef RR_SEL_ARB_TIMEOUT_EN
      if (!a && r[m_cur] && m_wait == TIMEOUT_CYC - 1) to_hit = 1'b1;
`endif
      if (a) m_cnt = (m_cnt + 1) % (1 << CNT_W);
      if (a || to_hit) begin
        m_last = m_cur;
        m_tmo  = to_hit;
        m_cur  = model_pick(r, m_last);
        m_wait = 0;
      end else if (!r[m_cur]) begin
        m_cur = -1;
      end else begin
        m_wait++;
      end
    end
    if (m_cur >= 0) m_sel = m_cur;
  endtask

  task automatic compare_all();
    check("valid",    32'(bus.valid),    32'(m_cur >= 0));
    check("sel",      32'(bus.sel),      32'(m_sel));
    check("grant",    32'(bus.grant),    (m_cur >= 0) ? (32'd1 << m_cur) : 32'd0);
    check("done_cnt", 32'(bus.done_cnt), 32'(m_cnt));
    check("timeout",  32'(bus.timeout),  32'(m_tmo));
  endtask

  // Compare the state left by the previous edge, then present inputs for the next one.
  task automatic cycle(input logic [3:0] r, input logic a);
    @(negedge clk);
    compare_all();
    bus.req = r;
    bus.ack = a;
    model_step(r, a);
  endtask

  initial begin
    logic [3:0] r;
    logic       a;

    rst_n   = 1'b0;
    bus.req = 4'b0000;
    bus.ack = 1'b0;
    model_reset();
    #12;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Idle with no requests
    repeat (5) cycle(4'b0000, 1'b0);

    // All requesting, ack every grant cycle: sel walks 0,1,2,3,0
    cycle(4'b1111, 1'b0);
    repeat (5) cycle(4'b1111, 1'b1);
    cycle(4'b0000, 1'b0);
    check("t2_cnt", 32'(bus.done_cnt), 32'(5 % (1 << CNT_W)));

    // Wrap past channel 3: last served is 1, requests on 0 and 1
    cycle(4'b0010, 1'b0);
    cycle(4'b0000, 1'b1);
    cycle(4'b0011, 1'b0);
    cycle(4'b0011, 1'b1);
    check("t3_sel0", 32'(bus.sel), 32'd0);
    cycle(4'b0011, 1'b0);
    check("t3_sel1", 32'(bus.sel), 32'd1);

    // Withdrawal of channel 2 and re-grant
    cycle(4'b0000, 1'b1);
    cycle(4'b0100, 1'b0);
    cycle(4'b0000, 1'b0);
    cycle(4'b0100, 1'b0);
    cycle(4'b0100, 1'b0);
    check("t4_sel2", 32'(bus.sel), 32'd2);

    // Asynchronous reset in the middle of a grant
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus.valid),    32'd0);
    check("arst_cnt",   32'(bus.done_cnt), 32'd0);
    check("arst_sel",   32'(bus.sel),      32'd0);
    check("arst_grant", 32'(bus.grant),    32'd0);
    bus.req = 4'b0000;
    bus.ack = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Single requester never acked: timeout release or indefinite hold
    repeat (100) cycle(4'b0001, 1'b0);
    cycle(4'b0000, 1'b0);

    // Random traffic: mostly sticky requests, sporadic acks and withdrawals
    r = 4'b0000;
    repeat (1500) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      a = ($urandom_range(0, 2) == 0);
      cycle(r, a);
    end
    cycle(4'b0000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
